// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared defaults, word type and arbiter states for the fp adder arbiter
package fp_pkg;
   localparam int EXP_LEN_DEF      = 8;
   localparam int MANTISSA_LEN_DEF = 23;
   localparam int W_DEF            = EXP_LEN_DEF + MANTISSA_LEN_DEF + 1;

   typedef logic [W_DEF-1:0] fp_word_t;

   typedef enum logic [2:0] {
      FLUSH,
      IDLE,
      ISSUE,
      WAIT,
      FLUSH_T,
      RESP
   } arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick of the first request strictly after a pointer
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any_valid
);
   logic [IW-1:0] cand;

   // Walk from farthest to nearest so the closest set bit after ptr is written last.
   always_comb begin
      grant     = '0;
      idx       = '0;
      cand      = '0;
      any_valid = |req;
      for (int k = N; k >= 1; k--) begin
         cand = IW'((int'(ptr) + k) % N);
         if (req[cand]) begin
            idx = cand;
         end
      end
      if (any_valid) begin
         grant[idx] = 1'b1;
      end
   end
endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin sharing of one multi-cycle float adder among N_REQ requesters
module fp_add_arbiter
   import fp_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int EXP_LEN      = EXP_LEN_DEF,
   parameter int MANTISSA_LEN = MANTISSA_LEN_DEF,
   parameter int TIMEOUT      = 63,
   localparam int W           = EXP_LEN + MANTISSA_LEN + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   resp_valid,
   input  logic [N_REQ-1:0]   resp_ready,
   output logic [W-1:0]       resp_sum,
   output logic               resp_err,
   output logic [W-1:0]       add_a,
   output logic [W-1:0]       add_b,
   output logic               add_start,
   input  logic [W-1:0]       add_sum,
   input  logic               add_done,
   output logic               busy
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   arb_state_t    state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] cur;
   logic [N_REQ-1:0] pick_grant;
   logic [IW-1:0] pick_idx;
   logic          pick_any;
   logic [W-1:0]  sel_a;
   logic [W-1:0]  sel_b;
   logic          cnt_last;

   rr_picker #(
      .N  (N_REQ),
      .IW (IW)
   ) u_picker (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (pick_grant),
      .idx       (pick_idx),
      .any_valid (pick_any)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (IW'(i) == pick_idx) begin
            sel_a = req_a[i*W +: W];
            sel_b = req_b[i*W +: W];
         end
      end
   end

   assign cnt_last  = (cnt == CW'(TIMEOUT - 1));
   assign req_ready = (state == IDLE) ? pick_grant : '0;

   // One counter serves the post-reset flush, the WAIT watchdog and the post-timeout flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FLUSH;
         cnt        <= '0;
         rr_ptr     <= IW'(N_REQ - 1);
         cur        <= '0;
         resp_valid <= '0;
         resp_sum   <= '0;
         resp_err   <= 1'b0;
         add_a      <= '0;
         add_b      <= '0;
         add_start  <= 1'b0;
         busy       <= 1'b1;
      end else begin
         case (state)
            FLUSH: begin
               if (cnt_last) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            IDLE: begin
               if (pick_any) begin
                  add_a     <= sel_a;
                  add_b     <= sel_b;
                  cur       <= pick_idx;
                  rr_ptr    <= pick_idx;
                  add_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               add_start <= 1'b0;
               cnt       <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               if (add_done) begin
                  resp_sum   <= add_sum;
                  resp_err   <= 1'b0;
                  resp_valid <= N_REQ'(1) << cur;
                  cnt        <= '0;
                  state      <= RESP;
               end else if (cnt_last) begin
                  resp_sum <= '0;
                  resp_err <= 1'b1;
                  cnt      <= '0;
                  state    <= FLUSH_T;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FLUSH_T: begin
               if (cnt_last) begin
                  resp_valid <= N_REQ'(1) << cur;
                  cnt        <= '0;
                  state      <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (resp_ready[cur]) begin
                  resp_valid <= '0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= FLUSH;
               cnt   <= '0;
               busy  <= 1'b1;
            end
         endcase
      end
   end
endmodule
